multi_rate_tick_gen: RTL

//   Parametrised N-channel programmable divider. Each channel produces a 50%-duty square

---
 rtl/tick_gen_pkg.sv | 15 +
 rtl/tick_gen_channel.sv | 113 +++++++++++
 rtl/multi_rate_tick_gen.sv | 83 ++++++++
 3 files changed

// File: rtl/tick_gen_pkg.sv
// Shared definitions for the multi-rate tick generator.
//   CNT_W_DEF        default counter / half-period width
//   DEFAULT_HALF_DEF half-period loaded at reset (2 Hz from a 100 MHz clock)
//   clamp_half()     maps a zero half-period to 1 so a channel can never stall
package tick_gen_pkg;

    localparam int          CNT_W_DEF        = 32;
    localparam int unsigned DEFAULT_HALF_DEF = 25_000_000;

    // Operates on 64 bits so any counter width up to 64 can share it.
    function automatic logic [63:0] clamp_half(input logic [63:0] x);
        return (x == 64'd0) ? 64'd1 : x;
    endfunction

endpackage

// File: rtl/tick_gen_channel.sv
// One divider channel: counter, active half-period, shadow half-period with
// pending flag, registered square output and 1-cycle tick.
//   clk, rst  rising-edge clock, asynchronous active-low reset
//   en        run enable (level); low holds cnt=0 and forces sq/tick low
//   restart   restart in phase: cnt=0, sq=0, pending shadow applied now
//   load      accepted config for this channel (already clamped)
//   load_val  new half-period
//   sq, tick  square output and toggle pulse
//   pending   a shadow half-period waits for the next toggle boundary
module tick_gen_channel
    import tick_gen_pkg::*;
#(
    parameter int          CNT_W        = CNT_W_DEF,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             sq,
    output logic             tick,
    output logic             pending
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             sq_q, sq_d;
    logic             tick_q, tick_d;
    logic             boundary;

    // cnt never exceeds half-1, so equality is enough to find the boundary.
    assign boundary = (cnt_q == (half_q - ONE));

    always_comb begin
        cnt_d     = cnt_q;
        half_d    = half_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        sq_d      = sq_q;
        tick_d    = 1'b0;
        if (restart) begin
            cnt_d     = '0;
            sq_d      = 1'b0;
            pending_d = 1'b0;
            if (load) begin
                half_d   = load_val;
                shadow_d = load_val;
            end else if (pending_q) begin
                half_d = shadow_q;
            end
        end else if (!en) begin
            // No waveform is running, so a new half-period can take effect
            // right away; loading goes through the shadow for one edge.
            cnt_d = '0;
            sq_d  = 1'b0;
            if (pending_q) begin
                half_d    = shadow_q;
                pending_d = 1'b0;
            end else if (load) begin
                shadow_d  = load_val;
                pending_d = 1'b1;
            end
        end else begin
            if (boundary) begin
                cnt_d  = '0;
                sq_d   = ~sq_q;
                tick_d = 1'b1;
                // Swap only here so no half-cycle is truncated or stretched.
                if (pending_q) begin
                    half_d    = shadow_q;
                    pending_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + ONE;
            end
            // load is only possible while nothing is pending, so a load at a
            // boundary simply becomes the next pending value.
            if (load) begin
                shadow_d  = load_val;
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            half_q    <= CNT_W'(DEFAULT_HALF);
            shadow_q  <= CNT_W'(DEFAULT_HALF);
            pending_q <= 1'b0;
            sq_q      <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            sq_q      <= sq_d;
            tick_q    <= tick_d;
        end
    end

    assign sq      = sq_q;
    assign tick    = tick_q;
    assign pending = pending_q;

endmodule

// File: rtl/multi_rate_tick_gen.sv
// N-channel programmable divider producing 50%-duty squares and toggle ticks
// as clock-enable style outputs, with a valid/ready half-period config port.
//   clk, rst      rising-edge clock, asynchronous active-low reset
//   en            per-channel run enable
//   sync_restart  1-cycle pulse restarting all channels in phase
//   cfg_valid     config request; cfg_ready accepts it
//   cfg_ch        target channel; cfg_half new half-period (0 -> 1)
//   cfg_err       1-cycle pulse for an accepted zero or out-of-range request
//   sq, tick      per-channel square output and toggle pulse
module multi_rate_tick_gen
    import tick_gen_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = CNT_W_DEF,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF,
    localparam int         CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_restart,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] tick
);

    logic [NUM_CH-1:0] pending;
    logic              ch_ok;
    logic              ready_sel;
    logic              accept;
    logic [CNT_W-1:0]  load_val;
    logic              cfg_err_q, cfg_err_d;

    // Loop decode avoids indexing past NUM_CH when it is not a power of two;
    // an out-of-range channel reports ready so the request drains as an error.
    always_comb begin
        ch_ok     = 1'b0;
        ready_sel = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                ch_ok     = 1'b1;
                ready_sel = ~pending[i];
            end
        end
    end

    assign cfg_ready = ready_sel;
    assign accept    = cfg_valid & ready_sel;
    assign load_val  = CNT_W'(clamp_half(64'(cfg_half)));
    assign cfg_err_d = accept & (~ch_ok | (cfg_half == '0));

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_gen_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en[g]),
            .restart  (sync_restart),
            .load     (accept & ch_ok & (cfg_ch == CH_W'(g))),
            .load_val (load_val),
            .sq       (sq[g]),
            .tick     (tick[g]),
            .pending  (pending[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

endmodule
